// File: rtl/ahb_dma_sequencer.sv
// ahb_dma_sequencer: pops command words and runs Write / Read / Verify word transfers between slave regs and the AHB masters.
// Latency: pop to go is 1 cycle; pushes/pops are combinational on full/available, at most one word per cycle.
// Backpressure: stalls on write_user_buffer_full or !read_user_data_available; an abort returns to IDLE at once.
// Optional Verify opcode, comparator and mismatch counter: define AHB_DMA_VERIFY_EN.
module ahb_dma_sequencer #(
  parameter int                      ADDRESSWIDTH    = 32,
  parameter int                      DATAWIDTH       = 32,
  parameter int                      NUMREGS         = 32,
  parameter logic [ADDRESSWIDTH-1:0] ADDRESS_BASE    = 32'h08000000,
  parameter logic [ADDRESSWIDTH-1:0] WDATA_ADDR_BASE = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  output logic                    r_fifo_read_enable,
  input  logic [DATAWIDTH-1:0]    r_fifo_read_data,
  input  logic                    r_fifo_empty,
  output logic [ADDRESSWIDTH-1:0] data_addr,
  input  logic [DATAWIDTH-1:0]    data,
  output logic                    write_control_go,
  output logic [ADDRESSWIDTH-1:0] write_control_write_base,
  output logic [ADDRESSWIDTH-1:0] write_control_write_length,
  output logic                    write_control_fixed_location,
  output logic [2:0]              write_data_size,
  input  logic                    write_control_done,
  input  logic                    write_abort,
  output logic                    write_user_write_buffer,
  output logic [DATAWIDTH-1:0]    write_user_buffer_data,
  input  logic                    write_user_buffer_full,
  output logic                    read_control_go,
  output logic [ADDRESSWIDTH-1:0] read_control_read_base,
  output logic [ADDRESSWIDTH-1:0] read_control_read_length,
  output logic                    read_control_fixed_location,
  output logic [2:0]              read_data_size,
  input  logic                    read_control_done,
  input  logic                    read_abort,
  output logic                    read_user_read_buffer,
  input  logic [DATAWIDTH-1:0]    read_user_buffer_data,
  input  logic                    read_user_data_available,
  input  logic [15:0]             rdwr_address,
  input  logic                    add_data_sel,
  output logic [DATAWIDTH-1:0]    display_data,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [15:0]             mismatch_count
);
  localparam int BPW = DATAWIDTH / 8;
  localparam int IW  = $clog2(NUMREGS);
  localparam int CW  = IW + 1;
  localparam logic [15:0] OP_WRITE = 16'hF00B;
  localparam logic [15:0] OP_READ  = 16'hDEAD;

  typedef enum logic [2:0] {IDLE, WR_GO, WR_DATA, WR_WAIT, RD_GO, RD_DATA, RD_WAIT} state_t;

  state_t                  state;
  logic [CW-1:0]           n_q, cnt_q, n_clamped;
  logic [ADDRESSWIDTH-1:0] len_q;
  logic                    wr_go_q, rd_go_q, done_q, error_q, verify_q;
  logic [DATAWIDTH-1:0]    bank [NUMREGS];
  logic [15:0]             opcode, cmd_n;
  logic                    op_write, op_read, op_verify, op_known;
  logic                    abort_any, wr_push, rd_pop, last_word;
  logic                    unused_ok;

  assign opcode    = r_fifo_read_data[31:16];
  assign cmd_n     = r_fifo_read_data[15:0];
  assign n_clamped = (cmd_n == 16'd0 || cmd_n > 16'(NUMREGS)) ? CW'(NUMREGS) : CW'(cmd_n);
  assign op_write  = (opcode == OP_WRITE);
  assign op_read   = (opcode == OP_READ);
`ifdef AHB_DMA_VERIFY_EN
  localparam logic [15:0] OP_VERIFY = 16'hC0DE;
  assign op_verify = (opcode == OP_VERIFY);
`else
  assign op_verify = 1'b0;
`endif
  assign op_known  = op_write | op_read | op_verify;

  // Abort wins over any data movement in the same cycle.
  assign abort_any          = write_abort | read_abort;
  assign r_fifo_read_enable = (state == IDLE) && !r_fifo_empty;
  assign wr_push            = (state == WR_DATA) && !write_user_buffer_full && !abort_any;
  assign rd_pop             = (state == RD_DATA) && read_user_data_available && !abort_any;
  assign last_word          = ((cnt_q + 1'b1) == n_q);

  // Main sequencer: command decode, word counting and registered go/done strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      n_q       <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      wr_go_q   <= 1'b0;
      rd_go_q   <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      verify_q  <= 1'b0;
      data_addr <= WDATA_ADDR_BASE;
    end else begin
      wr_go_q <= 1'b0;
      rd_go_q <= 1'b0;
      done_q  <= 1'b0;
      if (state != IDLE && abort_any) begin
        state     <= IDLE;
        error_q   <= 1'b1;
        data_addr <= WDATA_ADDR_BASE;
      end else begin
        case (state)
          IDLE: if (r_fifo_read_enable && op_known) begin
            n_q       <= n_clamped;
            len_q     <= ADDRESSWIDTH'(32'(n_clamped) * BPW);
            cnt_q     <= '0;
            error_q   <= 1'b0;
            verify_q  <= op_verify;
            data_addr <= WDATA_ADDR_BASE;
            if (op_write) begin
              state   <= WR_GO;
              wr_go_q <= 1'b1;
            end else begin
              state   <= RD_GO;
              rd_go_q <= 1'b1;
            end
          end
          WR_GO: state <= WR_DATA;
          WR_DATA: if (wr_push) begin
            data_addr <= data_addr + 1'b1;
            cnt_q     <= cnt_q + 1'b1;
            if (last_word) state <= WR_WAIT;
          end
          WR_WAIT: if (write_control_done) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
          RD_GO: state <= RD_DATA;
          RD_DATA: if (rd_pop) begin
            cnt_q <= cnt_q + 1'b1;
            if (verify_q) data_addr <= data_addr + 1'b1;
            if (last_word) state <= RD_WAIT;
          end
          RD_WAIT: if (read_control_done) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Capture bank: Read words land at the running index; aborts leave partial contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUMREGS; i++) bank[i] <= '0;
    end else if (rd_pop && !verify_q) begin
      bank[cnt_q[IW-1:0]] <= read_user_buffer_data;
    end
  end

`ifdef AHB_DMA_VERIFY_EN
  logic [15:0] mismatch_q;
  // Verify comparator: cleared when a Verify is accepted, saturates at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mismatch_q <= '0;
    end else if (state == IDLE && r_fifo_read_enable && op_verify) begin
      mismatch_q <= '0;
    end else if (rd_pop && verify_q && read_user_buffer_data != data && mismatch_q != 16'hFFFF) begin
      mismatch_q <= mismatch_q + 1'b1;
    end
  end
  assign mismatch_count = mismatch_q;
`else
  assign mismatch_count = '0;
`endif

  assign write_control_go             = wr_go_q;
  assign write_control_write_base     = wr_go_q ? ADDRESS_BASE : '0;
  assign write_control_write_length   = len_q;
  assign write_control_fixed_location = 1'b0;
  assign write_data_size              = 3'd2;
  assign write_user_write_buffer      = wr_push;
  assign write_user_buffer_data       = data;
  assign read_control_go              = rd_go_q;
  assign read_control_read_base       = rd_go_q ? ADDRESS_BASE : '0;
  assign read_control_read_length     = len_q;
  assign read_control_fixed_location  = 1'b0;
  assign read_data_size               = 3'd2;
  assign read_user_read_buffer        = rd_pop;
  assign busy                         = (state != IDLE);
  assign done                         = done_q;
  assign error                        = error_q;
  assign display_data = add_data_sel ? bank[rdwr_address[IW-1:0]]
                                     : DATAWIDTH'({busy, error_q, mismatch_count});
  assign unused_ok = ^rdwr_address[15:IW];
endmodule

// File: tb/tb_ahb_dma_sequencer.sv
// Bench for ahb_dma_sequencer: master/FIFO models drive inputs on the falling edge,
// a reference model queues expected go/push/done events, a monitor pops and compares them.
module tb_ahb_dma_sequencer;
  localparam int NR = 32;
  localparam logic [31:0] BASE = 32'h08000000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        r_fifo_read_enable, r_fifo_empty;
  logic [31:0] r_fifo_read_data, data_addr, data;
  logic        write_control_go, write_control_fixed_location, write_control_done, write_abort;
  logic [31:0] write_control_write_base, write_control_write_length, write_user_buffer_data;
  logic [2:0]  write_data_size, read_data_size;
  logic        write_user_write_buffer, write_user_buffer_full;
  logic        read_control_go, read_control_fixed_location, read_control_done, read_abort;
  logic [31:0] read_control_read_base, read_control_read_length, read_user_buffer_data;
  logic        read_user_read_buffer, read_user_data_available;
  logic [15:0] rdwr_address = 16'h0;
  logic        add_data_sel = 1'b0;
  logic [31:0] display_data;
  logic        busy, done, error;
  logic [15:0] mismatch_count;

  always #5 clk = ~clk;

  ahb_dma_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .r_fifo_read_enable(r_fifo_read_enable), .r_fifo_read_data(r_fifo_read_data), .r_fifo_empty(r_fifo_empty),
    .data_addr(data_addr), .data(data),
    .write_control_go(write_control_go), .write_control_write_base(write_control_write_base),
    .write_control_write_length(write_control_write_length),
    .write_control_fixed_location(write_control_fixed_location), .write_data_size(write_data_size),
    .write_control_done(write_control_done), .write_abort(write_abort),
    .write_user_write_buffer(write_user_write_buffer), .write_user_buffer_data(write_user_buffer_data),
    .write_user_buffer_full(write_user_buffer_full),
    .read_control_go(read_control_go), .read_control_read_base(read_control_read_base),
    .read_control_read_length(read_control_read_length),
    .read_control_fixed_location(read_control_fixed_location), .read_data_size(read_data_size),
    .read_control_done(read_control_done), .read_abort(read_abort),
    .read_user_read_buffer(read_user_read_buffer), .read_user_buffer_data(read_user_buffer_data),
    .read_user_data_available(read_user_data_available),
    .rdwr_address(rdwr_address), .add_data_sel(add_data_sel), .display_data(display_data),
    .busy(busy), .done(done), .error(error), .mismatch_count(mismatch_count)
  );

  // Slave register file and reference model state
  logic [31:0] regs [0:63];
  logic [31:0] bank_m [0:NR-1];
  logic [15:0] mm_m = 16'h0;
  logic        err_m = 1'b0;
  assign data = regs[data_addr[5:0]];

  logic [31:0] cmd_q[$], rd_src_q[$], rdf_q[$];
  logic [31:0] exp_wgo_q[$], exp_rgo_q[$], exp_wdat_q[$], exp_done_q[$];

  int checks = 0, errors = 0;
  int full_pct = 25;
  bit force_full = 0, abort_arm = 0, abort_hit = 0;
  bit do_cmd_pop = 0, do_rd_pop = 0, do_wr_push = 0;
  bit wr_active = 0, rd_active = 0, rd_early = 0;
  int wr_got = 0, wr_need = 0, wr_dly = 0, rd_pops = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // Command FIFO, write master and read master models: drive on falling edge, sample 1ns later.
  initial begin : bfm
    logic [31:0] tmp;
    r_fifo_empty = 1; r_fifo_read_data = 0; write_control_done = 0; write_abort = 0;
    write_user_buffer_full = 0; read_control_done = 0; read_abort = 0;
    read_user_buffer_data = 0; read_user_data_available = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        do_cmd_pop = 0; do_rd_pop = 0; do_wr_push = 0;
        continue;
      end
      if (abort_hit) begin
        rdf_q.delete(); rd_active = 0; read_control_done = 0; abort_hit = 0;
      end
      if (done && rd_active) begin
        rd_active = 0; read_control_done = 0;
      end
      if (do_cmd_pop && cmd_q.size() > 0) tmp = cmd_q.pop_front();
      if (do_rd_pop && rdf_q.size() > 0) begin tmp = rdf_q.pop_front(); rd_pops++; end
      if (do_wr_push) wr_got++;
      if (write_control_go) begin wr_active = 1; wr_got = 0; wr_dly = $urandom_range(0, 3); end
      if (read_control_go) begin
        rd_active = 1; rd_pops = 0;
        rd_early = ($urandom_range(0, 1) == 1) && !abort_arm;
        while (rd_src_q.size() > 0) rdf_q.push_back(rd_src_q.pop_front());
      end
      write_control_done = 0;
      if (wr_active && wr_got >= wr_need) begin
        if (wr_dly == 0) begin write_control_done = 1; wr_active = 0; end
        else wr_dly--;
      end
      if (rd_active && (rd_early || rdf_q.size() == 0)) read_control_done = 1;
      read_abort = 0;
      read_user_data_available = (rdf_q.size() > 0) && ($urandom_range(0, 3) != 0);
      if (abort_arm && rd_active && rd_pops == 1 && rdf_q.size() > 0) begin
        read_abort = 1; read_user_data_available = 1; abort_arm = 0; abort_hit = 1;
      end
      read_user_buffer_data  = (rdf_q.size() > 0) ? rdf_q[0] : 32'h0;
      write_user_buffer_full = force_full || ($urandom_range(0, 99) < full_pct);
      r_fifo_empty     = (cmd_q.size() == 0);
      r_fifo_read_data = r_fifo_empty ? 32'h0 : cmd_q[0];
      #1;
      do_cmd_pop = r_fifo_read_enable;
      do_rd_pop  = read_user_read_buffer;
      do_wr_push = write_user_write_buffer;
      if (abort_hit) chk("abort_pop_suppressed", {31'b0, read_user_read_buffer}, 32'h0);
    end
  end

  // Monitor: pops expected events whenever the DUT presents go / push / done.
  initial begin : mon
    forever begin
      @(negedge clk);
      #2;
      if (reset_n) begin
        if (write_control_go) begin
          if (exp_wgo_q.size() == 0) fail("unexpected_write_go");
          else begin
            chk("wgo_length", write_control_write_length, exp_wgo_q.pop_front());
            chk("wgo_base", write_control_write_base, BASE);
            chk("wgo_size_fixed", {28'b0, write_data_size, write_control_fixed_location}, 32'h4);
          end
        end else chk("wbase_no_go", write_control_write_base, 32'h0);
        if (read_control_go) begin
          if (exp_rgo_q.size() == 0) fail("unexpected_read_go");
          else begin
            chk("rgo_length", read_control_read_length, exp_rgo_q.pop_front());
            chk("rgo_base", read_control_read_base, BASE);
            chk("rgo_size_fixed", {28'b0, read_data_size, read_control_fixed_location}, 32'h4);
          end
        end
        if (write_user_buffer_full) chk("push_while_full", {31'b0, write_user_write_buffer}, 32'h0);
        if (write_user_write_buffer) begin
          if (exp_wdat_q.size() == 0) fail("unexpected_push");
          else chk("push_data", write_user_buffer_data, exp_wdat_q.pop_front());
        end
        if (done) begin
          if (exp_done_q.size() == 0) fail("unexpected_done");
          else begin
            chk("done_mismatch", {16'b0, mismatch_count}, exp_done_q.pop_front());
            chk("done_error", {31'b0, error}, 32'h0);
          end
        end
      end
    end
  end

  // Reference model: derive every expected event of one command from the command rules.
  task automatic issue(input logic [15:0] op, input logic [15:0] nraw, input int limit, input int bad);
    int n;
    logic [31:0] w;
    n = (nraw == 0 || nraw > NR) ? NR : int'(nraw);
    case (op)
      16'hF00B: begin
        wr_need = n; err_m = 0;
        exp_wgo_q.push_back(32'(n * 4));
        for (int i = 0; i < n; i++) exp_wdat_q.push_back(regs[2 + i]);
        exp_done_q.push_back({16'b0, mm_m});
      end
      16'hDEAD: begin
        err_m = 0;
        exp_rgo_q.push_back(32'(n * 4));
        for (int i = 0; i < n; i++) begin
          w = $urandom;
          rd_src_q.push_back(w);
          if (i < limit) bank_m[i] = w;
        end
        if (limit >= n) exp_done_q.push_back({16'b0, mm_m});
      end
`ifdef AHB_DMA_VERIFY_EN
      16'hC0DE: begin
        err_m = 0; mm_m = 0;
        exp_rgo_q.push_back(32'(n * 4));
        for (int i = 0; i < n; i++) begin
          w = regs[2 + i];
          if ((bad < 0 && $urandom_range(0, 3) == 0) || bad == i) begin
            w = w ^ (32'h1 << $urandom_range(0, 31));
            mm_m = mm_m + 16'h1;
          end
          rd_src_q.push_back(w);
        end
        exp_done_q.push_back({16'b0, mm_m});
      end
`endif
      default: ;
    endcase
    cmd_q.push_back({op, nraw});
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      #3;
      if (cmd_q.size() == 0 && !busy && !rd_active && !wr_active &&
          exp_done_q.size() == 0 && exp_wdat_q.size() == 0) break;
    end
    if (k == 3000) fail({"timeout_", name});
  endtask

  task automatic check_bank(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      @(negedge clk);
      add_data_sel = 1; rdwr_address = 16'(i);
      #1;
      chk($sformatf("bank%0d", i), display_data, bank_m[i]);
    end
    @(negedge clk);
    add_data_sel = 0;
    #1;
    chk("status_view", display_data, {14'b0, 1'b0, err_m, mm_m});
  endtask

  initial begin : stim
    int k;
    logic [15:0] op;
    for (int i = 0; i < 64; i++) regs[i] = $urandom;
    for (int i = 0; i < NR; i++) bank_m[i] = 32'h0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_fifo_re", {31'b0, r_fifo_read_enable}, 32'h0);
    chk("rst_data_addr", data_addr, 32'h2);
    chk("rst_flags", {28'b0, busy, done, error, write_control_go}, 32'h0);
    chk("rst_rgo_pop", {30'b0, read_control_go, read_user_read_buffer}, 32'h0);
    chk("rst_lengths", write_control_write_length | read_control_read_length, 32'h0);
    chk("rst_mismatch", {16'b0, mismatch_count}, 32'h0);
    chk("rst_display", display_data, 32'h0);
    @(negedge clk);
    reset_n = 1;

    // Write N=8 of 0x100..0x107 at full rate
    full_pct = 0;
    for (int i = 0; i < 8; i++) regs[2 + i] = 32'h100 + 32'(i);
    issue(16'hF00B, 16'd8, 8, -1);
    wait_idle("write8");

    // Write N=8 with full held three cycles mid-burst
    for (int i = 0; i < 8; i++) regs[2 + i] = 32'h200 + 32'(i);
    issue(16'hF00B, 16'd8, 8, -1);
    for (k = 0; k < 200; k++) begin
      @(negedge clk); #3;
      if (wr_got >= 3) break;
    end
    if (k == 200) fail("timeout_wr_got");
    force_full = 1;
    repeat (3) @(negedge clk);
    force_full = 0;
    wait_idle("write_full");
    full_pct = 25;

    // Read N=4 then read back through the display mux
    issue(16'hDEAD, 16'd4, 4, -1);
    wait_idle("read4");
    check_bank(4);

    // Verify N=4 with word 2 corrupted
    issue(16'hC0DE, 16'd4, 4, 2);
`ifdef AHB_DMA_VERIFY_EN
    wait_idle("verify4");
    chk("verify_mismatch", {16'b0, mismatch_count}, 32'h1);
`else
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #3;
      chk("verify_disabled_busy", {31'b0, busy}, 32'h0);
    end
    chk("verify_disabled_popped", 32'(cmd_q.size()), 32'h0);
    wait_idle("verify_disabled");
`endif
    check_bank(0);

    // Clamp: N=0 write, N=100 read
    issue(16'hF00B, 16'd0, NR, -1);
    wait_idle("write_n0");
    issue(16'hDEAD, 16'd100, NR, -1);
    wait_idle("read_n100");
    check_bank(NR);

    // read_abort on the second word of a Read
    abort_arm = 1;
    issue(16'hDEAD, 16'd4, 1, -1);
    wait_idle("read_abort");
    err_m = 1;
    chk("abort_error", {31'b0, error}, 32'h1);
    chk("abort_data_addr", data_addr, 32'h2);
    chk("abort_armed_used", {31'b0, abort_arm}, 32'h0);
    check_bank(4);

    // The next accepted command clears error
    issue(16'hF00B, 16'd2, 2, -1);
    wait_idle("write_after_abort");
    chk("error_cleared", {31'b0, error}, 32'h0);

    // Randomized command mix
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 64; i++) regs[i] = $urandom;
      case ($urandom_range(0, 3))
        0: op = 16'hF00B;
        1: op = 16'hDEAD;
        2: op = 16'hC0DE;
        default: begin
          op = 16'($urandom_range(0, 65535));
          if (op == 16'hF00B || op == 16'hDEAD || op == 16'hC0DE) op = 16'h1234;
        end
      endcase
      issue(op, 16'($urandom_range(0, 40)), NR, -1);
      wait_idle("random");
    end
    check_bank(NR);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
